// File: rtl/scr1_dmem_port_wdog_pkg.sv
// Shared memory-interface types and watchdog default constants for the
// data-memory router port watchdog.
package scr1_dmem_port_wdog_pkg;

    localparam int unsigned SCR1_DMEM_AWIDTH = 32;
    localparam int unsigned SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    // Per-port watchdog defaults; each router-port instance may override them.
    localparam int unsigned                  SCR1_DMEM_WDOG_ACK_TIMEOUT  = 16;
    localparam int unsigned                  SCR1_DMEM_WDOG_RESP_TIMEOUT = 64;
    localparam int unsigned                  SCR1_DMEM_WDOG_CNT_W        = 8;
    localparam int unsigned                  SCR1_DMEM_WDOG_ERRCNT_W     = 8;
    localparam logic [SCR1_DMEM_DWIDTH-1:0] SCR1_DMEM_WDOG_ERR_RDATA    = 32'hBADBADBA;

endpackage

// File: rtl/scr1_dmem_port_wdog_sat_cnt.sv
// Saturating up-counter with synchronous clear.
module scr1_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/scr1_dmem_port_wdog.sv
// Bus watchdog between a dmem router port and its slave: forwards traffic,
// converts stalled address/data phases into error responses and drains late replies.
module scr1_dmem_port_wdog
    import scr1_dmem_port_wdog_pkg::*;
#(
    parameter int unsigned                  ACK_TIMEOUT  = SCR1_DMEM_WDOG_ACK_TIMEOUT,
    parameter int unsigned                  RESP_TIMEOUT = SCR1_DMEM_WDOG_RESP_TIMEOUT,
    parameter logic [SCR1_DMEM_DWIDTH-1:0] ERR_RDATA    = SCR1_DMEM_WDOG_ERR_RDATA,
    parameter int unsigned                  CNT_W        = SCR1_DMEM_WDOG_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_req,
    output logic                          s_req_ack,
    input  type_scr1_mem_cmd_e            s_cmd,
    input  type_scr1_mem_width_e          s_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0]   s_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0]   s_wdata,
    output logic [SCR1_DMEM_DWIDTH-1:0]   s_rdata,
    output type_scr1_mem_resp_e           s_resp,
    output logic                          m_req,
    output type_scr1_mem_cmd_e            m_cmd,
    output type_scr1_mem_width_e          m_width,
    output logic [SCR1_DMEM_AWIDTH-1:0]   m_addr,
    output logic [SCR1_DMEM_DWIDTH-1:0]   m_wdata,
    input  logic                          m_req_ack,
    input  logic [SCR1_DMEM_DWIDTH-1:0]   m_rdata,
    input  type_scr1_mem_resp_e           m_resp,
    input  logic                          err_clr,
    output logic                          err_flag,
    output logic [SCR1_DMEM_WDOG_ERRCNT_W-1:0] err_cnt,
    output logic                          drain_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_ACKERR = 2'b10,
        ST_DRAIN  = 2'b11
    } state_e;

    // Last wait cycle index for each phase; a zero timeout disables its compare.
    localparam bit               ACK_EN    = (ACK_TIMEOUT != 0);
    localparam bit               RESP_EN   = (RESP_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_EN  ? ACK_TIMEOUT  - 1 : 0);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_EN ? RESP_TIMEOUT - 1 : 0);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout;

    assign m_cmd   = s_cmd;
    assign m_width = s_width;
    assign m_addr  = s_addr;
    assign m_wdata = s_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            err_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (timeout) begin
                err_flag <= 1'b1;
            end else if (err_clr) begin
                err_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        m_req      = 1'b0;
        s_req_ack  = 1'b0;
        s_resp     = SCR1_MEM_RESP_NOTRDY;
        s_rdata    = m_rdata;
        drain_busy = 1'b0;
        timeout    = 1'b0;

        case (state)
            ST_IDLE: begin
                m_req     = s_req;
                s_req_ack = m_req_ack;
                if (!s_req) begin
                    cnt_nxt = '0;
                end else if (m_req_ack) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = '0;
                end else if (ACK_EN && (cnt == ACK_LAST)) begin
                    // Forced ack releases the core; the error reply follows next cycle
                    s_req_ack = 1'b1;
                    state_nxt = ST_ACKERR;
                    cnt_nxt   = '0;
                    timeout   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_ACKERR: begin
                s_resp    = SCR1_MEM_RESP_RDY_ER;
                s_rdata   = ERR_RDATA;
                state_nxt = ST_IDLE;
            end
            ST_DATA: begin
                s_resp = m_resp;
                case (m_resp)
                    SCR1_MEM_RESP_NOTRDY: begin
                        if (RESP_EN && (cnt == RESP_LAST)) begin
                            s_resp    = SCR1_MEM_RESP_RDY_ER;
                            s_rdata   = ERR_RDATA;
                            state_nxt = ST_DRAIN;
                            cnt_nxt   = '0;
                            timeout   = 1'b1;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                    SCR1_MEM_RESP_RDY_OK: begin
                        m_req     = s_req;
                        s_req_ack = m_req_ack;
                        cnt_nxt   = '0;
                        state_nxt = (s_req && m_req_ack) ? ST_DATA : ST_IDLE;
                    end
                    default: begin
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                endcase
            end
            ST_DRAIN: begin
                drain_busy = 1'b1;
                if (m_resp != SCR1_MEM_RESP_NOTRDY) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Keep the slave and core handshakes quiet while reset is held
        if (rst) begin
            m_req     = 1'b0;
            s_req_ack = 1'b0;
        end
    end

    scr1_sat_cnt #(
        .W (SCR1_DMEM_WDOG_ERRCNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (timeout),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_scr1_dmem_port_wdog.sv
// Self-checking bench for scr1_dmem_port_wdog: directed vector table,
// randomized traffic against a wait-count reference model, saturation/clear corner.
module tb_scr1_dmem_port_wdog;
    import scr1_dmem_port_wdog_pkg::*;

    localparam int          ACK_TO  = 4;
    localparam int          RESP_TO = 8;
    localparam logic [31:0] ERRD    = 32'hBADBADBA;
    localparam logic [1:0]  NR = 2'd0, OK = 2'd1, ER = 2'd2;
    localparam int          P_ADDR = 0, P_DATA = 1, P_ERR = 2, P_DRAIN = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_req, s_req_ack, m_req, m_req_ack, err_clr, err_flag, drain_busy;
    type_scr1_mem_cmd_e   s_cmd, m_cmd;
    type_scr1_mem_width_e s_width, m_width;
    logic [31:0]          s_addr, s_wdata, s_rdata, m_addr, m_wdata, m_rdata;
    type_scr1_mem_resp_e  s_resp, m_resp;
    logic [7:0]           err_cnt;

    int tests = 0;
    int fails = 0;

    scr1_dmem_port_wdog #(
        .ACK_TIMEOUT  (ACK_TO),
        .RESP_TIMEOUT (RESP_TO),
        .ERR_RDATA    (ERRD),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_req      (s_req),
        .s_req_ack  (s_req_ack),
        .s_cmd      (s_cmd),
        .s_width    (s_width),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .s_resp     (s_resp),
        .m_req      (m_req),
        .m_cmd      (m_cmd),
        .m_width    (m_width),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_req_ack  (m_req_ack),
        .m_rdata    (m_rdata),
        .m_resp     (m_resp),
        .err_clr    (err_clr),
        .err_flag   (err_flag),
        .err_cnt    (err_cnt),
        .drain_busy (drain_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req, ack;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        clr;
        logic        e_mreq, e_ack;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        logic        e_drain, e_flag;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model: which phase the core transaction is in and how long it has waited
    int          ph = P_ADDR, waited = 0, nx_ph, nx_waited;
    bit          nx_to;
    bit          flag_m = 1'b0;
    int          cnt_m = 0;
    logic        e_mreq, e_ack, e_drain;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;

    function automatic vec_t mk(logic req, logic ack, logic [1:0] resp, logic [31:0] rd, logic clr,
                                logic emreq, logic eack, logic [1:0] eresp, logic [31:0] erd,
                                logic edrain, logic eflag, logic [7:0] ecnt);
        vec_t v;
        v.req = req; v.ack = ack; v.resp = resp; v.rdata = rd; v.clr = clr;
        v.e_mreq = emreq; v.e_ack = eack; v.e_resp = eresp; v.e_rdata = erd;
        v.e_drain = edrain; v.e_flag = eflag; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_eval();
        e_mreq = 1'b0; e_ack = 1'b0; e_resp = NR; e_rdata = m_rdata; e_drain = 1'b0;
        nx_ph = ph; nx_waited = waited; nx_to = 1'b0;
        if (ph == P_ADDR) begin
            e_mreq = s_req;
            e_ack  = m_req_ack;
            if (!s_req) nx_waited = 0;
            else if (m_req_ack) begin nx_ph = P_DATA; nx_waited = 0; end
            else if (waited + 1 == ACK_TO) begin
                e_ack = 1'b1; nx_ph = P_ERR; nx_waited = 0; nx_to = 1'b1;
            end else nx_waited = waited + 1;
        end else if (ph == P_ERR) begin
            e_resp = ER; e_rdata = ERRD; nx_ph = P_ADDR;
        end else if (ph == P_DATA) begin
            if (m_resp == SCR1_MEM_RESP_NOTRDY) begin
                if (waited + 1 == RESP_TO) begin
                    e_resp = ER; e_rdata = ERRD; nx_ph = P_DRAIN; nx_waited = 0; nx_to = 1'b1;
                end else nx_waited = waited + 1;
            end else if (m_resp == SCR1_MEM_RESP_RDY_OK) begin
                e_resp = OK; e_mreq = s_req; e_ack = m_req_ack; nx_waited = 0;
                nx_ph = (s_req && m_req_ack) ? P_DATA : P_ADDR;
            end else begin
                e_resp = ER; nx_waited = 0; nx_ph = P_ADDR;
            end
        end else begin
            e_drain = 1'b1;
            if (m_resp != SCR1_MEM_RESP_NOTRDY) nx_ph = P_ADDR;
        end
    endtask

    task automatic model_commit();
        ph = nx_ph;
        waited = nx_waited;
        if (nx_to) begin
            flag_m = 1'b1;
            cnt_m = (cnt_m >= 255) ? 255 : cnt_m + 1;
        end else if (err_clr) flag_m = 1'b0;
    endtask

    task automatic drive(input logic req, input logic ack, input logic [1:0] resp,
                         input logic [31:0] rd, input logic clr);
        @(negedge clk);
        s_req = req; m_req_ack = ack; m_resp = type_scr1_mem_resp_e'(resp);
        m_rdata = rd; err_clr = clr;
        s_addr = $urandom; s_wdata = $urandom;
        s_cmd = type_scr1_mem_cmd_e'(1'($urandom));
        s_width = type_scr1_mem_width_e'(2'($urandom));
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
    endtask

    task automatic model_check();
        check("m_req", 32'(m_req), 32'(e_mreq));
        check("s_req_ack", 32'(s_req_ack), 32'(e_ack));
        check("s_resp", 32'(s_resp), 32'(e_resp));
        if (e_resp != NR) check("s_rdata", s_rdata, e_rdata);
        check("drain_busy", 32'(drain_busy), 32'(e_drain));
        check("err_flag", 32'(err_flag), 32'(flag_m));
        check("err_cnt", 32'(err_cnt), 32'(cnt_m));
        check("m_addr", m_addr, s_addr);
        check("m_wdata", m_wdata, s_wdata);
    endtask

    task automatic mstep(input logic req, input logic ack, input logic [1:0] resp,
                         input logic [31:0] rd, input logic clr);
        drive(req, ack, resp, rd, clr);
        model_check();
        advance();
    endtask

    initial begin
        // Normal read, ack on 2nd cycle, RDY_OK after 3 NOTRDY cycles
        vecs.push_back(mk(1,0,NR,0,0,             1,0,NR,0,0,0,0));
        vecs.push_back(mk(1,1,NR,0,0,             1,1,NR,0,0,0,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,NR,0,0, 0,0,NR,0,0,0,0));
        vecs.push_back(mk(0,0,OK,32'h12345678,0,  0,0,OK,32'h12345678,0,0,0));
        // Back-to-back with no bubble
        vecs.push_back(mk(1,1,NR,0,0,             1,1,NR,0,0,0,0));
        vecs.push_back(mk(1,1,OK,32'h11111111,0,  1,1,OK,32'h11111111,0,0,0));
        vecs.push_back(mk(0,0,OK,32'h22222222,0,  0,0,OK,32'h22222222,0,0,0));
        // Address timeout: forced ack on 4th request cycle, error next cycle
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,NR,0,0, 1,0,NR,0,0,0,0));
        vecs.push_back(mk(1,0,NR,0,0,             1,1,NR,0,0,0,0));
        vecs.push_back(mk(0,0,NR,0,0,             0,0,ER,ERRD,0,1,1));
        // Response timeout at data cycle 8, late RDY_OK at data cycle 12
        vecs.push_back(mk(1,1,NR,0,0,             1,1,NR,0,0,1,1));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(0,0,NR,0,0, 0,0,NR,0,0,1,1));
        vecs.push_back(mk(0,0,NR,32'h55555555,0,  0,0,ER,ERRD,0,1,1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,1,NR,0,0, 0,0,NR,0,1,1,2));
        vecs.push_back(mk(1,1,OK,32'h77777777,0,  0,0,NR,0,1,1,2));
        vecs.push_back(mk(1,1,NR,0,0,             1,1,NR,0,0,1,2));
        // RDY_OK exactly in the response timeout cycle
        for (int i = 0; i < 7; i++) vecs.push_back(mk(0,0,NR,0,0, 0,0,NR,0,0,1,2));
        vecs.push_back(mk(0,0,OK,32'hCAFEF00D,0,  0,0,OK,32'hCAFEF00D,0,1,2));
        // Real ack exactly in the address timeout cycle, then slave RDY_ER passes through
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,NR,0,0, 1,0,NR,0,0,1,2));
        vecs.push_back(mk(1,1,NR,0,0,             1,1,NR,0,0,1,2));
        vecs.push_back(mk(0,0,ER,32'h0000A5A5,0,  0,0,ER,32'h0000A5A5,0,1,2));
        // err_clr alone clears the flag on the following edge
        vecs.push_back(mk(0,0,NR,0,1,             0,0,NR,0,0,1,2));
        vecs.push_back(mk(0,0,NR,0,0,             0,0,NR,0,0,0,2));

        rst = 1'b1; s_req = 1'b1; m_req_ack = 1'b1; m_resp = SCR1_MEM_RESP_NOTRDY;
        m_rdata = '0; err_clr = 1'b0; s_addr = '0; s_wdata = '0;
        s_cmd = SCR1_MEM_CMD_RD; s_width = SCR1_MEM_WIDTH_WORD;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_s_req_ack", 32'(s_req_ack), 32'd0);
        check("rst_s_resp", 32'(s_resp), 32'(NR));
        check("rst_drain_busy", 32'(drain_busy), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        s_req = 1'b0; m_req_ack = 1'b0; rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].ack, vecs[i].resp, vecs[i].rdata, vecs[i].clr);
            check($sformatf("v%0d_m_req", i), 32'(m_req), 32'(vecs[i].e_mreq));
            check($sformatf("v%0d_s_req_ack", i), 32'(s_req_ack), 32'(vecs[i].e_ack));
            check($sformatf("v%0d_s_resp", i), 32'(s_resp), 32'(vecs[i].e_resp));
            if (vecs[i].e_resp != NR)
                check($sformatf("v%0d_s_rdata", i), s_rdata, vecs[i].e_rdata);
            check($sformatf("v%0d_drain", i), 32'(drain_busy), 32'(vecs[i].e_drain));
            check($sformatf("v%0d_err_flag", i), 32'(err_flag), 32'(vecs[i].e_flag));
            check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].e_cnt));
            advance();
        end

        // Randomized traffic, slave biased toward stalling so both timeouts occur
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [1:0] rs;
            r  = int'($urandom_range(0, 11));
            rs = (r == 0) ? OK : (r == 1) ? ER : NR;
            mstep(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), rs,
                  $urandom, ($urandom_range(0, 15) == 0));
        end

        // Return to idle, then 300 back-to-back address timeouts
        mstep(0, 0, OK, 0, 0);
        mstep(0, 0, OK, 0, 0);
        for (int i = 0; i < 300; i++)
            for (int j = 0; j < 5; j++)
                mstep(1, 0, NR, 0, (i == 299) && (j == 3));
        drive(0, 0, NR, 0, 1);
        check("flag_set_wins_over_clr", 32'(err_flag), 32'd1);
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);
        advance();
        drive(0, 0, NR, 0, 0);
        check("flag_cleared", 32'(err_flag), 32'd0);
        check("err_cnt_kept", 32'(err_cnt), 32'd255);
        advance();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scr1_dmem_port_wdog.md
# scr1_dmem_port_wdog

Bus-watchdog stage between one data-memory router port and its slave, on the standard core memory request/response protocol. It forwards traffic transparently while the slave behaves. When the slave stalls the address phase or the data phase past a programmable limit, the block terminates the transaction toward the core with an error response. It then isolates the slave until any late response has drained, and records each event in status outputs.

## Interface
Parameters:
- ACK_TIMEOUT, 16: maximum address-phase wait cycles; 0 disables.
- RESP_TIMEOUT, 64: maximum data-phase wait cycles; 0 disables.
- ERR_RDATA, 32'hBADBADBA: read data returned with a watchdog error.
- CNT_W, 8: width of the timeout cycle counter. It must hold max(ACK_TIMEOUT, RESP_TIMEOUT).

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous assert, active-high
- s_req  in  1  request from router port
- s_req_ack  out  1  request accepted
- s_cmd  in  type_scr1_mem_cmd_e  command
- s_width  in  type_scr1_mem_width_e  access width
- s_addr  in  SCR1_DMEM_AWIDTH  address
- s_wdata  in  SCR1_DMEM_DWIDTH  write data
- s_rdata  out  SCR1_DMEM_DWIDTH  read data
- s_resp  out  type_scr1_mem_resp_e  response
- m_req, m_cmd, m_width, m_addr, m_wdata  out  (same widths)  toward slave
- m_req_ack  in  1  slave accept
- m_rdata  in  SCR1_DMEM_DWIDTH  slave read data
- m_resp  in  type_scr1_mem_resp_e  slave response
- err_clr  in  1  clears err_flag
- err_flag  out  1  sticky: a timeout has occurred
- err_cnt  out  8  saturating count of timeout events
- drain_busy  out  1  slave isolated, waiting for late response

## Operation
States: IDLE, DATA, ACKERR, DRAIN. Reset puts the block in IDLE with cnt=0, err_flag=0, err_cnt=0.

Reset values of outputs: m_req=0, s_req_ack=0, s_resp=NOTRDY, drain_busy=0.

Command, width, address and write data always pass s_* to m_* combinationally.

IDLE:
- m_req = s_req; s_req_ack = m_req_ack; s_resp = NOTRDY.
- cnt increments each cycle that s_req=1 and m_req_ack=0. It clears when s_req=0 or on accept.
- Accept (s_req & m_req_ack): go to DATA, cnt=0.
- Address-phase timeout: s_req & !m_req_ack & cnt==ACK_TIMEOUT-1. In that cycle s_req_ack=1 while m_req stays asserted. Go to ACKERR.

ACKERR:
- m_req=0, s_req_ack=0.
- s_resp=RDY_ER, s_rdata=ERR_RDATA for exactly one cycle, then IDLE.

DATA:
- s_resp = m_resp; s_rdata = m_rdata.
- While m_resp=NOTRDY: m_req=0, s_req_ack=0, cnt increments.
- On RDY_OK: m_req = s_req, s_req_ack = m_req_ack. This allows a back-to-back request; if accepted, stay in DATA with cnt=0, otherwise go to IDLE.
- On RDY_ER: m_req=0, s_req_ack=0, go to IDLE.
- Response timeout: m_resp==NOTRDY & cnt==RESP_TIMEOUT-1. In that cycle s_resp=RDY_ER and s_rdata=ERR_RDATA. Go to DRAIN.

DRAIN:
- m_req=0, s_req_ack=0, s_resp=NOTRDY, drain_busy=1.
- The first cycle with m_resp != NOTRDY discards that response and goes to IDLE.

Status:
- Each timeout (entry to ACKERR or DRAIN) sets err_flag and increments err_cnt, saturating at 255.
- err_clr clears err_flag only. If err_clr coincides with a new timeout, set wins.

## Timing
- No added latency on the success path. req/ack and resp are combinational pass-through, so zero extra cycles.
- An address-phase timeout produces RDY_ER on the cycle after the forced ack. A data-phase timeout produces RDY_ER in the timeout cycle itself.
- Simultaneous events:
  - A real m_req_ack in the ACK timeout cycle wins; no error.
  - A real RDY_OK/RDY_ER in the RESP timeout cycle wins; no error.
- A timeout parameter of 0 disables that comparison entirely.
- Reset mid-transaction returns to IDLE immediately. A pending slave response is not drained; the slave must share the reset.
- No combinational path from s_req to s_resp.

## Structure
- Protocol enums (type_scr1_mem_cmd_e, type_scr1_mem_width_e, type_scr1_mem_resp_e) and the AWIDTH/DWIDTH defines come from the shared memory-interface header.
- The state enum is local to the module.
- Default timeout constants go in the shared arch description header, so each router-port instance can override them.
- Natural sub-module: scr1_sat_cnt, a parameterized saturating counter with clear, used for err_cnt.

## Test plan
- Normal read: slave acks at cycle 2 and returns RDY_OK with 32'h12345678 after 3 NOTRDY cycles. Core sees the identical req_ack and resp cycles; err_cnt=0.
- Back-to-back: two requests with RDY_OK and the next accept in the same cycle. The block stays in DATA and both complete with no bubble.
- Address timeout: ACK_TIMEOUT=4, slave never acks. s_req_ack=1 on the 4th cycle of s_req, RDY_ER/32'hBADBADBA on the next cycle, err_flag=1, err_cnt=1.
- Response timeout then late response: RESP_TIMEOUT=8, slave answers RDY_OK at cycle 12. Core sees RDY_ER at data cycle 8, and drain_busy=1 until the late response. Any new s_req is held un-acked during drain and accepted once the block returns to IDLE.
- Race: RDY_OK exactly in the timeout cycle. Core sees RDY_OK with slave data and err_cnt is unchanged.
- Saturation/clear: 300 forced timeouts leave err_cnt=255. err_clr in the same cycle as a timeout leaves err_flag=1; err_clr alone then clears it.
